pc_step_controller: RTL and testbench

- Generates the program counter that drives the board's two-digit instruction-index display, upstream of the display decoder.
- Advances the PC one instruction per debounced push-button press, giving a single-step mode for the datapath.
- Applies branch redirects and a sticky halt at a programmable PC limit.
- Also emits a one-cycle step strobe that the datapath uses as its commit enable.

---
 rtl/pc_step_controller.sv | 169 ++++++++++++++++
 tb/tb_pc_step_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_step_controller.sv
// pc_step_controller
//   Single-step program counter for the two-digit instruction-index display.
//   A debounced push-button press advances the PC by one instruction (or to a
//   branch target), emitting a one-cycle step strobe that the datapath uses as
//   its commit enable. A step whose destination lies beyond PC_MAX freezes the
//   PC and sets a sticky halt flag that only reset clears.
//
// Ports
//   clk           in   system clock
//   reset         in   asynchronous active-high reset
//   key_n         in   raw push-button, active-low, asynchronous to clk
//   branch_taken  in   next PC is branch_target instead of pc+4 (step cycle only)
//   branch_target in   branch destination byte address (low two bits ignored)
//   pc            out  current program counter, word aligned, never above PC_MAX
//   step_pulse    out  one-cycle strobe; datapath commits instruction at pc
//   halted        out  sticky; a step would have exceeded PC_MAX
`timescale 1ns/1ps

module pc_step_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned PC_WIDTH        = 32,
    parameter int unsigned PC_RESET        = 0,
    parameter int unsigned PC_MAX          = 396
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_n,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic                step_pulse,
    output logic                halted
);

    localparam int unsigned         CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]    CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [PC_WIDTH-1:0] PC_LIMIT = PC_WIDTH'(PC_MAX);
    localparam logic [PC_WIDTH-1:0] PC_INIT  = PC_WIDTH'(PC_RESET);
    localparam logic [PC_WIDTH:0]   PC_INC   = (PC_WIDTH + 1)'(4);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    // Button synchronizer; both flops rest at 1 (button released).
    logic r_sync1;
    logic r_sync2;

    // Debounce FSM.
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_press_accept;

    // PC datapath.
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_step;
    logic                r_halted;
    logic [PC_WIDTH:0]   w_pc_plus4;
    logic [PC_WIDTH-1:0] w_pc_nxt;
    logic                w_step_halts;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The counter holds the length of the current run of samples at the new
    // level; a level change is accepted on the sample where the run would
    // reach DEBOUNCE_CYCLES+1, so the counter itself never exceeds CNT_DONE.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_press_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_sync2) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (r_sync2) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= CNT_DONE) begin
                    w_state_nxt    = PRESSED;
                    w_cnt_nxt      = '0;
                    w_press_accept = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (r_sync2) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (!r_sync2) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= CNT_DONE) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Extra carry bit catches pc+4 wrapping past the top of the address space.
    always_comb begin
        w_pc_plus4   = {1'b0, r_pc} + PC_INC;
        w_pc_nxt     = branch_taken ? {branch_target[PC_WIDTH-1:2], 2'b00}
                                    : w_pc_plus4[PC_WIDTH-1:0];
        w_step_halts = w_pc_plus4[PC_WIDTH] || (w_pc_nxt > PC_LIMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= PC_INIT;
            r_step   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_step <= w_press_accept && !r_halted;
            // The strobe cycle presents the old pc; the PC moves on the edge
            // that ends it.
            if (r_step) begin
                if (w_step_halts) begin
                    r_halted <= 1'b1;
                end else begin
                    r_pc <= w_pc_nxt;
                end
            end
        end
    end

    assign pc         = r_pc;
    assign step_pulse = r_step;
    assign halted     = r_halted;

endmodule

// File: tb/tb_pc_step_controller.sv
// tb_pc_step_controller
//   Directed bench for pc_step_controller with DEBOUNCE_CYCLES=4, PC_MAX=396.
//   A cycle-level behavioural model predicts pc/step_pulse/halted and is
//   compared on every falling edge outside reset; directed literal checks pin
//   the key timing points and boundary cases.
`timescale 1ns/1ps

module tb_pc_step_controller;

    localparam int unsigned DEB    = 4;
    localparam int unsigned PCW    = 32;
    localparam longint unsigned PMAX = 396;

    logic           clk;
    logic           reset;
    logic           key_n;
    logic           branch_taken;
    logic [PCW-1:0] branch_target;
    logic [PCW-1:0] pc;
    logic           step_pulse;
    logic           halted;

    int n_tests;
    int n_fail;
    int n_pulses;

    pc_step_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .PC_WIDTH(PCW),
        .PC_RESET(0),
        .PC_MAX(396)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_n(key_n),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .pc(pc),
        .step_pulse(step_pulse),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: key_n reaches the debouncer two edges late; a level
    // change is accepted once DEB+1 consecutive delayed samples disagree with
    // the accepted level. An accepted press yields a strobe for one cycle,
    // and the PC moves when that strobe cycle ends.
    typedef struct {
        logic            k1;
        logic            k2;
        logic            level;
        int unsigned     run;
        logic            pulse;
        longint unsigned pc;
        logic            halted;
    } model_t;

    localparam model_t M_RESET = '{k1: 1'b1, k2: 1'b1, level: 1'b1, run: 0,
                                   pulse: 1'b0, pc: 0, halted: 1'b0};

    function automatic model_t model_step(input model_t m, input logic kn,
                                          input logic bt, input logic [PCW-1:0] tgt);
        model_t n;
        longint unsigned dest;
        n = m;
        n.k1 = kn;
        n.k2 = m.k1;
        n.pulse = 1'b0;
        if (m.pulse) begin
            dest = bt ? (64'(tgt) / 4) * 4 : m.pc + 4;
            if (m.pc + 4 > 64'h0000_0000_FFFF_FFFF || dest > PMAX)
                n.halted = 1'b1;
            else
                n.pc = dest;
        end
        if (m.k2 == m.level) begin
            n.run = 0;
        end else if (m.run + 1 > DEB) begin
            n.level = m.k2;
            n.run = 0;
            if (m.k2 == 1'b0 && !m.halted) n.pulse = 1'b1;
        end else begin
            n.run = m.run + 1;
        end
        return n;
    endfunction

    model_t m;

    always @(posedge clk or posedge reset) begin
        if (reset) m <= M_RESET;
        else       m <= model_step(m, key_n, branch_taken, branch_target);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("model_pc", 64'(pc), 64'(m.pc));
            check("model_step_pulse", 64'(step_pulse), 64'(m.pulse));
            check("model_halted", 64'(halted), 64'(m.halted));
            if (step_pulse === 1'b1) n_pulses++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int hold, input int rel);
        key_n = 1'b0;
        cycles(hold);
        key_n = 1'b1;
        cycles(rel);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        n_tests = 0;
        n_fail = 0;
        n_pulses = 0;
        reset = 1'b1;
        key_n = 1'b1;
        branch_taken = 1'b0;
        branch_target = '0;

        // 1: reset values before any clock edge, then idle
        #1;
        check("t1_reset_pc", 64'(pc), 64'd0);
        check("t1_reset_pulse", 64'(step_pulse), 64'd0);
        check("t1_reset_halted", 64'(halted), 64'd0);
        cycles(3);
        reset = 1'b0;
        cycles(20);
        check("t1_idle_pc", 64'(pc), 64'd0);
        check("t1_idle_halted", 64'(halted), 64'd0);
        check("t1_idle_pulses", 64'(n_pulses), 64'd0);

        // 2: single press latency; pulse only after E6, pc moves after E7
        p0 = n_pulses;
        key_n = 1'b0;
        cycles(6);
        check("t2_pulse_after_E5", 64'(step_pulse), 64'd0);
        cycles(1);
        check("t2_pulse_after_E6", 64'(step_pulse), 64'd1);
        check("t2_pc_during_pulse", 64'(pc), 64'd0);
        cycles(1);
        check("t2_pulse_after_E7", 64'(step_pulse), 64'd0);
        check("t2_pc_after_E7", 64'(pc), 64'd4);
        cycles(22);
        check("t2_one_pulse_held", 64'(n_pulses - p0), 64'd1);
        key_n = 1'b1;
        cycles(10);
        press(10, 10);
        check("t2_pc_second_press", 64'(pc), 64'd8);
        check("t2_two_pulses", 64'(n_pulses - p0), 64'd2);

        // 3: bounce shorter than the debounce window is rejected
        p0 = n_pulses;
        key_n = 1'b0; cycles(3);
        key_n = 1'b1; cycles(1);
        key_n = 1'b0; cycles(3);
        key_n = 1'b1; cycles(10);
        check("t3_bounce_pc", 64'(pc), 64'd8);
        check("t3_bounce_pulses", 64'(n_pulses - p0), 64'd0);
        press(10, 10);
        check("t3_clean_pc", 64'(pc), 64'd12);
        check("t3_clean_pulses", 64'(n_pulses - p0), 64'd1);

        // 4: branch with unaligned target, then sequential step
        do_reset();
        press(10, 10);
        press(10, 10);
        check("t4_pc_before_branch", 64'(pc), 64'd8);
        branch_taken = 1'b1;
        branch_target = 32'h0000_002E;
        press(10, 10);
        branch_taken = 1'b0;
        check("t4_branch_pc", 64'(pc), 64'h2C);
        press(10, 10);
        check("t4_seq_pc", 64'(pc), 64'h30);

        // 5: PC limit and sticky halt
        for (int i = 0; i < 87; i++) press(10, 10);
        check("t5_pc_at_max", 64'(pc), 64'd396);
        check("t5_not_halted_yet", 64'(halted), 64'd0);
        press(10, 10);
        check("t5_pc_frozen", 64'(pc), 64'd396);
        check("t5_halted", 64'(halted), 64'd1);
        p0 = n_pulses;
        press(10, 10);
        press(10, 10);
        check("t5_no_pulse_halted", 64'(n_pulses - p0), 64'd0);
        check("t5_pc_still_max", 64'(pc), 64'd396);
        check("t5_still_halted", 64'(halted), 64'd1);
        do_reset();
        check("t5_reset_clears_halt", 64'(halted), 64'd0);
        branch_taken = 1'b1;
        branch_target = 32'h0000_0400;
        press(10, 10);
        branch_taken = 1'b0;
        branch_target = '0;
        check("t5_far_branch_pc", 64'(pc), 64'd0);
        check("t5_far_branch_halted", 64'(halted), 64'd1);

        // 6: asynchronous reset mid-debounce, key held through release
        do_reset();
        press(10, 10);
        press(10, 10);
        press(10, 10);
        check("t6_pc_before", 64'(pc), 64'd12);
        p0 = n_pulses;
        key_n = 1'b0;
        cycles(5);
        reset = 1'b1;
        #1;
        check("t6_async_pc", 64'(pc), 64'd0);
        check("t6_async_halted", 64'(halted), 64'd0);
        check("t6_async_pulse", 64'(step_pulse), 64'd0);
        cycles(2);
        reset = 1'b0;
        cycles(6);
        check("t6_pulse_after_E5", 64'(step_pulse), 64'd0);
        cycles(1);
        check("t6_pulse_after_E6", 64'(step_pulse), 64'd1);
        cycles(1);
        check("t6_pc_after_E7", 64'(pc), 64'd4);
        key_n = 1'b1;
        cycles(10);
        check("t6_one_pulse", 64'(n_pulses - p0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
